// File: rtl/systolic_pkg.sv
// Shared types for the systolic row sequencer: row tags and sequencer states.
package systolic_pkg;

  typedef enum logic [1:0] {
    ROW_W    = 2'b00,
    ROW_IN   = 2'b01,
    ROW_PS   = 2'b10,
    ROW_INPS = 2'b11
  } row_type_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    STALL  = 3'd2,
    WDRAIN = 3'd3,
    GAP    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/systolic_row_hold_reg.sv
// Single-entry capture register for one tagged row; 1-cycle load, no backpressure of its own.
// Clear has priority over load so a reset always drops the held row.
module systolic_row_hold_reg
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int RW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic               load_i,
  input  row_type_t          type_i,
  input  logic [RW-1:0]      row_i,
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [N*WIDTH-1:0] partial_i,
  output row_type_t          type_o,
  output logic [RW-1:0]      row_o,
  output logic [N*WIDTH-1:0] data_o,
  output logic [N*WIDTH-1:0] partial_o
);

  row_type_t          type_q;
  logic [RW-1:0]      row_q;
  logic [N*WIDTH-1:0] data_q;
  logic [N*WIDTH-1:0] partial_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      type_q    <= ROW_W;
      row_q     <= '0;
      data_q    <= '0;
      partial_q <= '0;
    end else if (load_i) begin
      type_q    <= type_i;
      row_q     <= row_i;
      data_q    <= data_i;
      partial_q <= partial_i;
    end
  end

  assign type_o    = type_q;
  assign row_o     = row_q;
  assign data_o    = data_q;
  assign partial_o = partial_q;

endmodule

// File: rtl/systolic_array_row_sequencer.sv
// Feeds tagged rows into the systolic array: strobe one cycle after capture, in_ready back one cycle later.
// Holds the row (in_ready low) while the array FIFO is full, weights are still draining, or the gap runs.
module systolic_array_row_sequencer
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int GAP_W = 8,
  localparam int RW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_type,
  input  logic [RW-1:0]      in_row,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N*WIDTH-1:0] in_partial,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic               fifo_has_space,
  input  logic               drained,
  output logic               weight_en,
  output logic               input_en,
  output logic               partial_en,
  output logic [RW-1:0]      row_in_en,
  output logic [RW-1:0]      row_ps_en,
  output logic [N*WIDTH-1:0] array_in,
  output logic [N*WIDTH-1:0] array_in_partials,
  output logic               weights_valid,
  output logic               err_no_weights,
  output logic               busy
);

  seq_state_t         state_q, state_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  row_type_t          hold_type;
  logic [RW-1:0]      hold_row;
  logic [N*WIDTH-1:0] hold_data, hold_partial;

  logic               capture;
  row_type_t          cur_type;
  logic               wv;
  logic [N-1:0]       row_bit;

  logic [1:0]         src_type;
  logic [RW-1:0]      src_row;
  logic [N*WIDTH-1:0] src_data, src_partial;

  logic               weight_en_q, weight_en_d;
  logic               input_en_q, input_en_d;
  logic               partial_en_q, partial_en_d;
  logic [RW-1:0]      row_in_q, row_in_d;
  logic [RW-1:0]      row_ps_q, row_ps_d;
  logic [N*WIDTH-1:0] array_in_q, array_in_d;
  logic [N*WIDTH-1:0] array_ps_q, array_ps_d;
  logic               err_q, err_d;

  assign wv       = &mask_q;
  assign in_ready = (state_q == IDLE) && !nRST;
  assign capture  = in_valid && in_ready;
  assign cur_type = row_type_t'(in_type);
  assign row_bit  = {{(N-1){1'b0}}, 1'b1} << hold_row;

  systolic_row_hold_reg #(.N(N), .WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .clr_i     (nRST),
    .load_i    (capture),
    .type_i    (cur_type),
    .row_i     (in_row),
    .data_i    (in_data),
    .partial_i (in_partial),
    .type_o    (hold_type),
    .row_o     (hold_row),
    .data_o    (hold_data),
    .partial_o (hold_partial)
  );

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q <= IDLE;
      mask_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          if (cur_type == ROW_W) begin
            state_d = (wv && !drained) ? WDRAIN : ISSUE;
          end else if (!wv) begin
            state_d = IDLE;
          end else if (!fifo_has_space) begin
            state_d = STALL;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A weight issued over a complete set starts a fresh set.
        if (hold_type == ROW_W) begin
          mask_d = wv ? row_bit : (mask_q | row_bit);
        end
        if (hold_type != ROW_W && cfg_gap != '0) begin
          state_d = GAP;
          gap_d   = cfg_gap;
        end else begin
          state_d = IDLE;
        end
      end
      STALL:  if (fifo_has_space) state_d = ISSUE;
      WDRAIN: if (drained) state_d = ISSUE;
      GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered, so they are computed from the state being entered.
  always_comb begin
    src_type    = hold_type;
    src_row     = hold_row;
    src_data    = hold_data;
    src_partial = hold_partial;
    if (state_q == IDLE) begin
      src_type    = in_type;
      src_row     = in_row;
      src_data    = in_data;
      src_partial = in_partial;
    end
    weight_en_d  = 1'b0;
    input_en_d   = 1'b0;
    partial_en_d = 1'b0;
    row_in_d     = '0;
    row_ps_d     = '0;
    array_in_d   = '0;
    array_ps_d   = '0;
    if (state_d == ISSUE) begin
      if (src_type == ROW_W) begin
        weight_en_d = 1'b1;
        row_in_d    = src_row;
        array_in_d  = src_data;
      end
      if (src_type[0]) begin
        input_en_d = 1'b1;
        row_in_d   = src_row;
        array_in_d = src_data;
      end
      if (src_type[1]) begin
        partial_en_d = 1'b1;
        row_ps_d     = src_row;
        array_ps_d   = src_partial;
      end
    end
    err_d = capture && (cur_type != ROW_W) && !wv;
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      weight_en_q  <= 1'b0;
      input_en_q   <= 1'b0;
      partial_en_q <= 1'b0;
      row_in_q     <= '0;
      row_ps_q     <= '0;
      array_in_q   <= '0;
      array_ps_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      weight_en_q  <= weight_en_d;
      input_en_q   <= input_en_d;
      partial_en_q <= partial_en_d;
      row_in_q     <= row_in_d;
      row_ps_q     <= row_ps_d;
      array_in_q   <= array_in_d;
      array_ps_q   <= array_ps_d;
      err_q        <= err_d;
    end
  end

  assign weight_en         = weight_en_q;
  assign input_en          = input_en_q;
  assign partial_en        = partial_en_q;
  assign row_in_en         = row_in_q;
  assign row_ps_en         = row_ps_q;
  assign array_in          = array_in_q;
  assign array_in_partials = array_ps_q;
  assign weights_valid     = wv;
  assign err_no_weights    = err_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_array_row_sequencer.sv
// Bench for the row sequencer: table of directed cycles, corner sequences, then random traffic vs a timeline model.
`timescale 1ns/1ps
module tb_systolic_array_row_sequencer;

  logic        clk, nRST, in_valid, in_ready;
  logic [1:0]  in_type, in_row;
  logic [63:0] in_data, in_partial;
  logic [7:0]  cfg_gap;
  logic        fifo_has_space, drained;
  logic        weight_en, input_en, partial_en;
  logic [1:0]  row_in_en, row_ps_en;
  logic [63:0] array_in, array_in_partials;
  logic        weights_valid, err_no_weights, busy;

  systolic_array_row_sequencer #(.N(4), .WIDTH(16), .GAP_W(8)) dut (
    .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_row(in_row), .in_data(in_data), .in_partial(in_partial),
    .cfg_gap(cfg_gap), .fifo_has_space(fifo_has_space), .drained(drained),
    .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
    .row_in_en(row_in_en), .row_ps_en(row_ps_en), .array_in(array_in),
    .array_in_partials(array_in_partials), .weights_valid(weights_valid),
    .err_no_weights(err_no_weights), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic [1:0]  typ;
    logic [1:0]  row;
    logic [63:0] dat;
    logic [63:0] par;
    logic [7:0]  gap;
    logic        spc;
    logic        drn;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic        ie;
    logic        pe;
    logic [1:0]  ri;
    logic [1:0]  rp;
    logic [63:0] ain;
    logic [63:0] aps;
    logic        wv;
    logic        err;
    logic        busy;
  } out_t;

  typedef struct {
    in_t  i;
    bit   chk;
    out_t e;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // Reference model: expected strobes for the current cycle plus a few timestamps.
  bit         mdl_on = 0;
  logic [3:0] m_mask = '0;
  bit         m_pend = 0;
  bit         m_pdrain = 0;
  in_t        m_prec;
  out_t       m_cur = '0;
  int         m_free = 0;

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic in_t mk_in(input logic rst, input logic vld, input logic [1:0] typ,
                                input logic [1:0] row, input logic [63:0] dat);
    in_t x;
    x.rst = rst; x.vld = vld; x.typ = typ; x.row = row; x.dat = dat;
    x.par = '0; x.gap = '0; x.spc = 1'b1; x.drn = 1'b1;
    return x;
  endfunction

  function automatic out_t mk_out(input logic rdy, input logic we, input logic ie, input logic [1:0] ri,
                                  input logic [63:0] ain, input logic wv, input logic err, input logic bsy);
    out_t o;
    o = '0;
    o.rdy = rdy; o.we = we; o.ie = ie; o.ri = ri; o.ain = ain;
    o.wv = wv; o.err = err; o.busy = bsy;
    return o;
  endfunction

  function automatic out_t mk_issue(input in_t r);
    out_t o;
    o = '0;
    if (r.typ == 2'b00) begin o.we = 1'b1; o.ri = r.row; o.ain = r.dat; end
    if (r.typ[0]) begin o.ie = 1'b1; o.ri = r.row; o.ain = r.dat; end
    if (r.typ[1]) begin o.pe = 1'b1; o.rp = r.row; o.aps = r.par; end
    return o;
  endfunction

  function automatic bit m_strobe();
    return m_cur.we | m_cur.ie | m_cur.pe;
  endfunction

  function automatic bit m_idle();
    return !m_pend && !m_strobe() && (cyc_n >= m_free);
  endfunction

  task automatic chk_out(input string nm, input out_t a, input out_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %h want %h", nm, cyc_n, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got %h want %h", nm, cyc_n, a, e);
    end
  endtask

  task automatic model_adv(input in_t x);
    bit   idle, wv;
    out_t nx;
    idle = m_idle();
    wv   = &m_mask;
    nx   = '0;
    if (x.rst) begin
      m_mask = '0; m_pend = 0; m_free = cyc_n + 1; mdl_on = 1;
    end else begin
      if (m_cur.we) m_mask = wv ? (4'b0001 << m_cur.ri) : (m_mask | (4'b0001 << m_cur.ri));
      if (m_strobe()) m_free = cyc_n + 1 + ((m_cur.ie | m_cur.pe) ? int'(x.gap) : 0);
      if (m_pend) begin
        if (m_pdrain ? x.drn : x.spc) begin nx = mk_issue(m_prec); m_pend = 0; end
      end else if (idle && x.vld) begin
        if (x.typ == 2'b00) begin
          if (wv && !x.drn) begin m_pend = 1; m_pdrain = 1; m_prec = x; end
          else nx = mk_issue(x);
        end else if (!wv) begin
          nx.err = 1'b1;
        end else if (!x.spc) begin
          m_pend = 1; m_pdrain = 0; m_prec = x;
        end else begin
          nx = mk_issue(x);
        end
      end
    end
    m_cur = nx;
  endtask

  // One clock: drive after the rising edge, sample at the falling edge, check against the model.
  task automatic cyc(input in_t x, output out_t o);
    out_t e;
    @(posedge clk);
    #1;
    nRST = x.rst; in_valid = x.vld; in_type = x.typ; in_row = x.row;
    in_data = x.dat; in_partial = x.par; cfg_gap = x.gap;
    fifo_has_space = x.spc; drained = x.drn;
    @(negedge clk);
    o.rdy = in_ready; o.we = weight_en; o.ie = input_en; o.pe = partial_en;
    o.ri = row_in_en; o.rp = row_ps_en; o.ain = array_in; o.aps = array_in_partials;
    o.wv = weights_valid; o.err = err_no_weights; o.busy = busy;
    if (mdl_on) begin
      e = m_cur;
      e.rdy  = !x.rst && m_idle();
      e.wv   = &m_mask;
      e.busy = m_pend || m_strobe() || (cyc_n < m_free);
      chk_out("model", o, e);
    end
    model_adv(x);
    cyc_n++;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, cycle %0d", cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [13];
    in_t  x, idle_in;
    out_t o, z;
    int   nstr, cnt, bad;
    int   t [4];
    logic [7:0] g_cur;

    nRST = 1'b1; in_valid = 1'b0; in_type = '0; in_row = '0; in_data = '0;
    in_partial = '0; cfg_gap = '0; fifo_has_space = 1'b1; drained = 1'b1;

    // Reset, input before weights, then a four-row weight set at gap 0.
    tbl[0]  = '{mk_in(1,0,0,0,0),            0, mk_out(0,0,0,0,0,0,0,0)};
    tbl[1]  = '{mk_in(1,0,0,0,0),            1, mk_out(0,0,0,0,0,0,0,0)};
    tbl[2]  = '{mk_in(0,1,1,2,rep(16'h00BB)), 1, mk_out(1,0,0,0,0,0,0,0)};
    tbl[3]  = '{mk_in(0,0,0,0,0),            1, mk_out(1,0,0,0,0,0,1,0)};
    tbl[4]  = '{mk_in(0,1,0,0,rep(16'h0001)), 1, mk_out(1,0,0,0,0,0,0,0)};
    tbl[5]  = '{mk_in(0,1,0,1,rep(16'h0002)), 1, mk_out(0,1,0,0,rep(16'h0001),0,0,1)};
    tbl[6]  = '{mk_in(0,1,0,1,rep(16'h0002)), 1, mk_out(1,0,0,0,0,0,0,0)};
    tbl[7]  = '{mk_in(0,1,0,2,rep(16'h0003)), 1, mk_out(0,1,0,1,rep(16'h0002),0,0,1)};
    tbl[8]  = '{mk_in(0,1,0,2,rep(16'h0003)), 1, mk_out(1,0,0,0,0,0,0,0)};
    tbl[9]  = '{mk_in(0,1,0,3,rep(16'h0004)), 1, mk_out(0,1,0,2,rep(16'h0003),0,0,1)};
    tbl[10] = '{mk_in(0,1,0,3,rep(16'h0004)), 1, mk_out(1,0,0,0,0,0,0,0)};
    tbl[11] = '{mk_in(0,0,0,0,0),            1, mk_out(0,1,0,3,rep(16'h0004),0,0,1)};
    tbl[12] = '{mk_in(0,0,0,0,0),            1, mk_out(1,0,0,0,0,1,0,0)};

    for (int k = 0; k < 13; k++) begin
      cyc(tbl[k].i, o);
      if (tbl[k].chk) chk_out($sformatf("tbl%0d", k), o, tbl[k].e);
    end

    idle_in = mk_in(0,0,0,0,0);

    // Back-pressure on an input+partial row.
    x = idle_in; x.spc = 0; x.vld = 1; x.typ = 2'b11; x.row = 2'd1;
    x.dat = rep(16'hA5A5); x.par = rep(16'h5A5A);
    cyc(x, o);
    chk1("bp_ready", o.rdy, 1);
    x.vld = 0;
    nstr = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(x, o);
      nstr += int'(o.we | o.ie | o.pe);
    end
    chk1("bp_no_strobe", nstr, 0);
    x.spc = 1;
    cyc(x, o);
    cyc(x, o);
    chk1("bp_strobes", {o.ie, o.pe, o.ri, o.rp}, {1'b1, 1'b1, 2'd1, 2'd1});
    chk1("bp_data", o.ain, rep(16'hA5A5));
    chk1("bp_partial", o.aps, rep(16'h5A5A));

    // Gap of 4 with in_valid held: strobes 6 cycles apart, in_ready low in the gap.
    x = idle_in; x.gap = 8'd4; x.vld = 1; x.typ = 2'b01;
    cnt = 0; bad = 0;
    for (int k = 0; k < 4; k++) t[k] = 0;
    for (int n = 0; n < 40 && cnt < 4; n++) begin
      x.row = 2'(n); x.dat = rep(16'(n + 16'h0100));
      cyc(x, o);
      if (cnt > 0 && n > t[cnt-1] && n <= t[cnt-1] + 4 && o.rdy) bad++;
      if (o.ie) begin t[cnt] = n; cnt++; end
    end
    chk1("gap_count", cnt, 4);
    for (int k = 1; k < 4; k++) chk1($sformatf("gap_spacing%0d", k), t[k] - t[k-1], 6);
    chk1("gap_ready_low", bad, 0);
    x = idle_in; x.gap = 8'd4;
    for (int k = 0; k < 6; k++) cyc(x, o);

    // Weight reload while the array is not drained.
    x = idle_in; x.drn = 0; x.vld = 1; x.typ = 2'b00; x.row = 2'd0; x.dat = rep(16'h00F0);
    cyc(x, o);
    x.vld = 0;
    nstr = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(x, o);
      nstr += int'(o.we);
    end
    chk1("wd_held", {nstr[7:0], o.busy, o.wv}, {8'd0, 1'b1, 1'b1});
    x.drn = 1;
    cyc(x, o);
    cyc(x, o);
    chk1("wd_issue", {o.we, o.ri, o.ain}, {1'b1, 2'd0, rep(16'h00F0)});
    cyc(x, o);
    chk1("wd_wv_drop", o.wv, 0);

    // Complete the new set, then reset while an input row is stalled.
    for (int r = 1; r < 4; r++) begin
      x = idle_in; x.vld = 1; x.typ = 2'b00; x.row = 2'(r); x.dat = rep(16'(r * 16'h0011));
      cyc(x, o);
      x.vld = 0;
      cyc(x, o);
    end
    cyc(idle_in, o);
    chk1("reload_wv", o.wv, 1);
    x = idle_in; x.spc = 0; x.vld = 1; x.typ = 2'b01; x.row = 2'd3; x.dat = rep(16'hBEEF);
    cyc(x, o);
    x.vld = 0;
    cyc(x, o);
    cyc(x, o);
    x.rst = 1;
    cyc(x, o);
    x.rst = 0; x.spc = 1;
    cyc(x, o);
    z = '0; z.rdy = 1'b1;
    chk_out("rst_outputs", o, z);
    nstr = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(x, o);
      nstr += int'(o.we | o.ie | o.pe);
    end
    chk1("rst_dropped", {nstr[7:0], o.wv}, {8'd0, 1'b0});

    // Random traffic against the model.
    g_cur = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) g_cur = 8'($urandom_range(0, 3));
      x.rst = ($urandom_range(0, 199) == 0);
      x.vld = ($urandom_range(0, 4) < 3);
      x.typ = ($urandom_range(0, 9) < 4) ? 2'd0 : 2'($urandom_range(1, 3));
      x.row = 2'($urandom_range(0, 3));
      x.dat = {$urandom, $urandom};
      x.par = {$urandom, $urandom};
      x.gap = g_cur;
      x.spc = ($urandom_range(0, 3) != 0);
      x.drn = ($urandom_range(0, 3) != 0);
      cyc(x, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_array_row_sequencer.md
Name: systolic_array_row_sequencer

Overview:
- Upstream feeder for systolic_array. Accepts tagged matrix rows (weight / input / partial / input+partial) on a valid/ready stream and drives the array's row-load controls.
- Issues one row per cycle at most, with a programmable inter-row gap.
- Respects array back-pressure (fifo_has_space) and the weight-reload hazard (drained).
- Replaces hand-sequenced row loading between the memory side and the array.

Parameters:
- N, 4, array dimension (rows/cols).
- WIDTH, 16, element width in bits.
- GAP_W, 8, width of the cfg_gap counter.

Ports:
- clk  in  1  clock.
- nRST  in  1  reset; synchronous, active-high (nRST=1 resets on the clk edge).
- in_valid  in  1  row offered.
- in_ready  out  1  sequencer can capture a row.
- in_type  in  2  00 weight, 01 input, 10 partial, 11 input+partial.
- in_row  in  $clog2(N)  target row index.
- in_data  in  N*WIDTH  weight or input row.
- in_partial  in  N*WIDTH  partial-sum row.
- cfg_gap  in  GAP_W  idle cycles after each input/partial issue.
- fifo_has_space  in  1  from array; input/partial issue allowed.
- drained  in  1  from array; no computation in flight.
- weight_en  out  1  weight row load strobe.
- input_en  out  1  input row load strobe.
- partial_en  out  1  partial row load strobe.
- row_in_en  out  $clog2(N)  input/weight row index.
- row_ps_en  out  $clog2(N)  partial row index.
- array_in  out  N*WIDTH  row data.
- array_in_partials  out  N*WIDTH  partial data.
- weights_valid  out  1  all N weight rows of the current set loaded.
- err_no_weights  out  1  one-cycle pulse; input/partial row dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, weight mask 0, gap counter 0, hold register cleared. Reset mid-operation drops any held row; no strobe fires in the cycle after reset.
- in_ready = (state==IDLE) && !nRST. A transfer occurs on in_valid && in_ready at edge k and captures type, row and data into the hold register.
- All array-side outputs are registered. A strobe is high for exactly one cycle. Data and index outputs are 0 whenever all strobes are low.
- States:
  - IDLE: on capture, choose the next state:
    - type 00 with weights_valid=1 and drained=0 → WDRAIN.
    - type 00 otherwise → ISSUE.
    - type 01/10/11 with weights_valid=0 → IDLE; err_no_weights pulses at cycle k+1; row dropped.
    - type 01/10/11 with fifo_has_space=0 → STALL.
    - otherwise → ISSUE.
  - ISSUE (one cycle): drive strobes and data.
    - Weight: weight_en=1, row_in_en=row, array_in=data.
    - Input bit (type[0]): input_en=1, row_in_en=row, array_in=data.
    - Partial bit (type[1]): partial_en=1, row_ps_en=row, array_in_partials=partial.
    - Next state: GAP if input/partial and cfg_gap!=0; otherwise IDLE.
  - STALL: wait until fifo_has_space=1, then ISSUE in the next cycle.
  - WDRAIN: wait until drained=1, then ISSUE in the next cycle.
  - GAP: count cfg_gap cycles (sampled at ISSUE), then IDLE.
- Latency: with no stall, the strobe appears in cycle k+1 and in_ready returns at k+2 (gap 0). Sustained throughput is one row per 2 cycles with gap 0, and per 2+cfg_gap cycles otherwise.
- Weight mask (N bits):
  - Issuing weight row r sets bit r; weights_valid=&mask.
  - The first weight issue after weights_valid=1 clears the mask to only bit r, so weights_valid drops.
  - A duplicate row within an incomplete set overwrites the row; the mask is unchanged.
- fifo_has_space is sampled only in IDLE/STALL; a deassertion during ISSUE does not cancel the strobe.
- No arithmetic on data; the row passes bit-exact.

Decomposition:
- Shared package systolic_pkg:
  - row_type_t enum (ROW_W=2'b00, ROW_IN=2'b01, ROW_PS=2'b10, ROW_INPS=2'b11).
  - seq_state_t enum (IDLE, ISSUE, STALL, WDRAIN, GAP).
- Sub-module systolic_row_hold_reg: the single-entry capture register (type/row/data/partial) with load and clear.

Test Plan (N=4, WIDTH=16):
- Weight load: 4 weight rows, rows 0..3, data 16'h0001..16'h0004 per lane, gap 0 → four weight_en pulses spaced 2 cycles apart, each matching row and data; weights_valid=1 one cycle after the fourth strobe.
- Input before weights: after reset, type 01 row 2 → err_no_weights pulse at k+1, no input_en, in_ready high at k+1.
- Back-pressure: weights loaded, fifo_has_space=0, type 11 row 1 → no strobe for 5 cycles. Release fifo_has_space → input_en and partial_en both high in the same cycle, row_in_en=row_ps_en=1.
- Gap: cfg_gap=4, four type 01 rows back-to-back with in_valid held → input_en pulses 6 cycles apart; in_ready low during GAP.
- Weight reload hazard: weights_valid=1, drained=0, type 00 row 0 → held in WDRAIN. Raise drained=1 → weight_en the next cycle; weights_valid drops to 0.
- Reset mid-STALL: assert nRST while a row is held → all outputs 0 next cycle, the row is never issued, mask=0.
